// File: rtl/tetris_pkg.sv
// Shared playfield geometry, cell/piece types, the commit FSM state encoding
// and the tetromino offset table used by the piece commit writer.
package tetris_pkg;

    localparam int ROWS   = 20;
    localparam int COLS   = 10;
    localparam int CELL_W = 3;

    // Sized copies of the geometry for counter arithmetic.
    localparam logic signed [5:0] LAST_ROW  = 6'(ROWS - 1);
    localparam logic [3:0]        LAST_COL  = 4'(COLS - 1);
    localparam logic [4:0]        MAX_LINES = 5'(ROWS);

    typedef logic [CELL_W-1:0] cell_t;

    typedef enum logic [2:0] {
        EMPTY = 3'd0,
        I     = 3'd1,
        O     = 3'd2,
        T     = 3'd3,
        S     = 3'd4,
        Z     = 3'd5,
        J     = 3'd6,
        L     = 3'd7
    } piece_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_CHECK = 3'd2,
        ST_COPY  = 3'd3,
        ST_FILL  = 3'd4,
        ST_DONE  = 3'd5
    } commit_state_t;

    // Each entry is {dr[1:0], dc[1:0]} inside the 4x4 bounding box,
    // indexed [piece][rotation][cell]. EMPTY has no cells; its entries are unused.
    localparam logic [3:0] SHAPE [8][4][4] = '{
        '{'{4'h0, 4'h0, 4'h0, 4'h0}, '{4'h0, 4'h0, 4'h0, 4'h0},
          '{4'h0, 4'h0, 4'h0, 4'h0}, '{4'h0, 4'h0, 4'h0, 4'h0}},   // EMPTY
        '{'{4'h4, 4'h5, 4'h6, 4'h7}, '{4'h2, 4'h6, 4'hA, 4'hE},
          '{4'h8, 4'h9, 4'hA, 4'hB}, '{4'h1, 4'h5, 4'h9, 4'hD}},   // I
        '{'{4'h1, 4'h2, 4'h5, 4'h6}, '{4'h1, 4'h2, 4'h5, 4'h6},
          '{4'h1, 4'h2, 4'h5, 4'h6}, '{4'h1, 4'h2, 4'h5, 4'h6}},   // O
        '{'{4'h1, 4'h4, 4'h5, 4'h6}, '{4'h1, 4'h5, 4'h6, 4'h9},
          '{4'h4, 4'h5, 4'h6, 4'h9}, '{4'h1, 4'h4, 4'h5, 4'h9}},   // T
        '{'{4'h1, 4'h2, 4'h4, 4'h5}, '{4'h1, 4'h5, 4'h6, 4'hA},
          '{4'h5, 4'h6, 4'h8, 4'h9}, '{4'h0, 4'h4, 4'h5, 4'h9}},   // S
        '{'{4'h0, 4'h1, 4'h5, 4'h6}, '{4'h2, 4'h5, 4'h6, 4'h9},
          '{4'h4, 4'h5, 4'h9, 4'hA}, '{4'h1, 4'h4, 4'h5, 4'h8}},   // Z
        '{'{4'h0, 4'h4, 4'h5, 4'h6}, '{4'h1, 4'h2, 4'h5, 4'h9},
          '{4'h4, 4'h5, 4'h6, 4'hA}, '{4'h1, 4'h5, 4'h8, 4'h9}},   // J
        '{'{4'h2, 4'h4, 4'h5, 4'h6}, '{4'h1, 4'h5, 4'h9, 4'hA},
          '{4'h4, 4'h5, 4'h6, 4'h8}, '{4'h0, 4'h1, 4'h5, 4'h9}}    // L
    };

    // Where to go once a source row has been handled: keep scanning while
    // src is still a real row, otherwise zero-fill any rows left above dst.
    function automatic commit_state_t row_exit_state(input logic [5:0] src,
                                                     input logic [5:0] dst);
        if (!src[5]) begin
            return ST_CHECK;
        end else if (!dst[5]) begin
            return ST_FILL;
        end else begin
            return ST_DONE;
        end
    endfunction

endpackage

// File: rtl/piece_cell_decoder.sv
// Maps (piece, rotation, bounding-box origin, cell index) to one absolute
// playfield cell and flags whether that cell lies inside the grid.
module piece_cell_decoder
    import tetris_pkg::*;
(
    input  logic [2:0] i_type,
    input  logic [1:0] i_rot,
    input  logic [5:0] i_origin_row,
    input  logic [4:0] i_origin_col,
    input  logic [1:0] i_k,
    output logic [4:0] o_row,
    output logic [3:0] o_col,
    output logic       o_in_bounds
);

    logic [3:0]        w_off;
    logic signed [6:0] w_row;
    logic signed [5:0] w_col;
    logic              w_row_ok;
    logic              w_col_ok;

    assign w_off = SHAPE[i_type][i_rot][i_k];

    // One extra bit of headroom so origin+3 can never wrap back into range.
    assign w_row = {i_origin_row[5], i_origin_row} + {5'b0, w_off[3:2]};
    assign w_col = {i_origin_col[4], i_origin_col} + {4'b0, w_off[1:0]};

    assign w_row_ok = !w_row[6] && (w_row[5:0] < 6'(ROWS));
    assign w_col_ok = !w_col[5] && (w_col[4:0] < 5'(COLS));

    assign o_row       = w_row[4:0];
    assign o_col       = w_col[3:0];
    // An EMPTY piece has no cells at all, so nothing is ever in bounds.
    assign o_in_bounds = (piece_t'(i_type) != EMPTY) && w_row_ok && w_col_ok;

endmodule

// File: rtl/piece_commit_writer.sv
// Writes a locked piece into the playfield grid store, then compacts the
// grid bottom-up, removing full rows and zero-filling the vacated top rows.
module piece_commit_writer
    import tetris_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              lock_valid,
    output logic              lock_ready,
    input  logic [2:0]        piece_type,
    input  logic [1:0]        piece_rot,
    input  logic [5:0]        origin_row,
    input  logic [4:0]        origin_col,
    output logic [4:0]        rd_row,
    output logic [3:0]        rd_col,
    input  logic [CELL_W-1:0] rd_data,
    output logic              wr_en,
    output logic [4:0]        wr_row,
    output logic [3:0]        wr_col,
    output logic [CELL_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [4:0]        lines_cleared,
    output logic              oob
);

    commit_state_t     r_state;
    logic [2:0]        r_type;
    logic [1:0]        r_rot;
    logic [5:0]        r_orow;
    logic [4:0]        r_ocol;
    logic [1:0]        r_k;
    logic [3:0]        r_col;
    logic signed [5:0] r_src;
    logic signed [5:0] r_dst;
    logic              r_full;
    logic [4:0]        r_lines;
    logic              r_oob;

    logic [4:0]        w_cell_row;
    logic [3:0]        w_cell_col;
    logic              w_cell_in;
    logic              w_col_last;
    logic              w_row_full;
    logic signed [5:0] w_src_dec;
    logic signed [5:0] w_dst_dec;

    piece_cell_decoder u_decoder (
        .i_type       (r_type),
        .i_rot        (r_rot),
        .i_origin_row (r_orow),
        .i_origin_col (r_ocol),
        .i_k          (r_k),
        .o_row        (w_cell_row),
        .o_col        (w_cell_col),
        .o_in_bounds  (w_cell_in)
    );

    assign w_col_last = (r_col == LAST_COL);
    // Fullness including the cell being read this cycle.
    assign w_row_full = r_full && (rd_data != '0);
    assign w_src_dec  = r_src - 6'sd1;
    assign w_dst_dec  = r_dst - 6'sd1;

    // Status outputs follow the registered state directly.
    assign lock_ready    = (r_state == ST_IDLE);
    assign busy          = (r_state != ST_IDLE);
    assign done          = (r_state == ST_DONE);
    assign lines_cleared = r_lines;
    assign oob           = r_oob;

    // Grid port steering: reads and writes must land in the same cycle as
    // the state that owns them, so they are decoded from the state registers.
    always_comb begin
        rd_row  = '0;
        rd_col  = '0;
        wr_en   = 1'b0;
        wr_row  = '0;
        wr_col  = '0;
        wr_data = '0;
        case (r_state)
            ST_WRITE: begin
                wr_en   = w_cell_in;
                wr_row  = w_cell_row;
                wr_col  = w_cell_col;
                wr_data = r_type;
            end
            ST_CHECK: begin
                rd_row = r_src[4:0];
                rd_col = r_col;
            end
            ST_COPY: begin
                rd_row  = r_src[4:0];
                rd_col  = r_col;
                wr_en   = 1'b1;
                wr_row  = r_dst[4:0];
                wr_col  = r_col;
                wr_data = rd_data;
            end
            ST_FILL: begin
                wr_en  = 1'b1;
                wr_row = r_dst[4:0];
                wr_col = r_col;
            end
            default: begin
            end
        endcase
    end

    // Commit sequencer: piece write, then row-by-row scan/copy, then top fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_type  <= '0;
            r_rot   <= '0;
            r_orow  <= '0;
            r_ocol  <= '0;
            r_k     <= '0;
            r_col   <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_full  <= 1'b0;
            r_lines <= '0;
            r_oob   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (lock_valid) begin
                        r_type  <= piece_type;
                        r_rot   <= piece_rot;
                        r_orow  <= origin_row;
                        r_ocol  <= origin_col;
                        r_k     <= '0;
                        r_lines <= '0;
                        r_oob   <= 1'b0;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if ((r_type != 3'd0) && !w_cell_in) begin
                        r_oob <= 1'b1;
                    end
                    r_k <= r_k + 2'd1;
                    if (r_k == 2'd3) begin
                        r_src   <= LAST_ROW;
                        r_dst   <= LAST_ROW;
                        r_full  <= 1'b1;
                        r_col   <= '0;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_full <= w_row_full;
                    r_col  <= w_col_last ? 4'd0 : r_col + 4'd1;
                    if (w_col_last) begin
                        if (w_row_full) begin
                            // Drop this row: dst stays, so the next kept row lands here.
                            if (r_lines < MAX_LINES) begin
                                r_lines <= r_lines + 5'd1;
                            end
                            r_src   <= w_src_dec;
                            r_full  <= 1'b1;
                            r_state <= row_exit_state(w_src_dec, r_dst);
                        end else if (r_src == r_dst) begin
                            // Row already sits where it belongs.
                            r_src   <= w_src_dec;
                            r_dst   <= w_dst_dec;
                            r_full  <= 1'b1;
                            r_state <= row_exit_state(w_src_dec, w_dst_dec);
                        end else begin
                            r_state <= ST_COPY;
                        end
                    end
                end
                ST_COPY: begin
                    r_col <= w_col_last ? 4'd0 : r_col + 4'd1;
                    if (w_col_last) begin
                        r_src   <= w_src_dec;
                        r_dst   <= w_dst_dec;
                        r_full  <= 1'b1;
                        r_state <= row_exit_state(w_src_dec, w_dst_dec);
                    end
                end
                ST_FILL: begin
                    r_col <= w_col_last ? 4'd0 : r_col + 4'd1;
                    if (w_col_last) begin
                        r_dst <= w_dst_dec;
                        if (w_dst_dec[5]) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piece_commit_writer.sv
// Bench for piece_commit_writer: hosts a behavioural grid store, runs directed
// and random commits, and compares against a row-list compaction model.
module tb_piece_commit_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       lock_valid;
    logic       lock_ready;
    logic [2:0] piece_type;
    logic [1:0] piece_rot;
    logic [5:0] origin_row;
    logic [4:0] origin_col;
    logic [4:0] rd_row;
    logic [3:0] rd_col;
    logic [2:0] rd_data;
    logic       wr_en;
    logic [4:0] wr_row;
    logic [3:0] wr_col;
    logic [2:0] wr_data;
    logic       busy;
    logic       done;
    logic [4:0] lines_cleared;
    logic       oob;

    int n_cmp = 0;
    int n_mis = 0;

    logic [2:0]  grid [20][10];
    logic [29:0] exp_rows [20];
    int          exp_lines;
    int          exp_copied;
    int          exp_writes;
    int          exp_oob;

    always #5 clk = ~clk;

    piece_commit_writer dut (
        .clk           (clk),
        .reset         (reset),
        .lock_valid    (lock_valid),
        .lock_ready    (lock_ready),
        .piece_type    (piece_type),
        .piece_rot     (piece_rot),
        .origin_row    (origin_row),
        .origin_col    (origin_col),
        .rd_row        (rd_row),
        .rd_col        (rd_col),
        .rd_data       (rd_data),
        .wr_en         (wr_en),
        .wr_row        (wr_row),
        .wr_col        (wr_col),
        .wr_data       (wr_data),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .oob           (oob)
    );

    // Grid store: combinational read, registered write.
    assign rd_data = (rd_row < 5'd20 && rd_col < 4'd10) ? grid[rd_row][rd_col] : 3'd0;

    always @(posedge clk) begin
        if (wr_en && wr_row < 5'd20 && wr_col < 4'd10) begin
            grid[wr_row][wr_col] <= wr_data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // 4x4 occupancy bitmap per piece/rotation, bit index = 4*row + col.
    function automatic logic [15:0] shape_mask(input int t, input int r);
        logic [4:0] key;
        key = {t[2:0], r[1:0]};
        case (key)
            5'b001_00: return 16'h00F0;  5'b001_01: return 16'h4444;
            5'b001_10: return 16'h0F00;  5'b001_11: return 16'h2222;
            5'b010_00, 5'b010_01, 5'b010_10, 5'b010_11: return 16'h0066;
            5'b011_00: return 16'h0072;  5'b011_01: return 16'h0262;
            5'b011_10: return 16'h0270;  5'b011_11: return 16'h0232;
            5'b100_00: return 16'h0036;  5'b100_01: return 16'h0462;
            5'b100_10: return 16'h0360;  5'b100_11: return 16'h0231;
            5'b101_00: return 16'h0063;  5'b101_01: return 16'h0264;
            5'b101_10: return 16'h0630;  5'b101_11: return 16'h0132;
            5'b110_00: return 16'h0071;  5'b110_01: return 16'h0226;
            5'b110_10: return 16'h0470;  5'b110_11: return 16'h0322;
            5'b111_00: return 16'h0074;  5'b111_01: return 16'h0622;
            5'b111_10: return 16'h0170;  5'b111_11: return 16'h0223;
            default:   return 16'h0000;
        endcase
    endfunction

    function automatic logic [29:0] grid_row(input int r);
        logic [29:0] v;
        v = '0;
        for (int c = 0; c < 10; c++) v[c*3 +: 3] = grid[r][c];
        return v;
    endfunction

    function automatic bit row_is_full(input logic [29:0] v);
        for (int c = 0; c < 10; c++) if (v[c*3 +: 3] == 3'd0) return 1'b0;
        return 1'b1;
    endfunction

    // Reference: place the piece, keep non-full rows in bottom-up order and
    // restack them from row 19 upward; everything above becomes empty.
    task automatic build_model(input int t, input int r, input int orow, input int ocol);
        logic [15:0] m;
        logic [29:0] post [20];
        int          keep [$];
        int          row;
        int          col;
        m = shape_mask(t, r);
        for (int rr = 0; rr < 20; rr++) post[rr] = grid_row(rr);
        exp_writes = 0;
        exp_oob    = 0;
        for (int b = 0; b < 16; b++) begin
            if (m[b]) begin
                row = orow + b / 4;
                col = ocol + b % 4;
                if (row >= 0 && row < 20 && col >= 0 && col < 10) begin
                    post[row][col*3 +: 3] = t[2:0];
                    exp_writes++;
                end else begin
                    exp_oob = 1;
                end
            end
        end
        for (int rr = 19; rr >= 0; rr--) if (!row_is_full(post[rr])) keep.push_back(rr);
        exp_lines  = 20 - keep.size();
        exp_copied = 0;
        for (int rr = 0; rr < 20; rr++) exp_rows[rr] = '0;
        foreach (keep[i]) begin
            if (19 - i != keep[i]) exp_copied++;
            exp_rows[19 - i] = post[keep[i]];
        end
    endtask

    task automatic clear_grid();
        for (int r = 0; r < 20; r++) for (int c = 0; c < 10; c++) grid[r][c] <= 3'd0;
    endtask

    task automatic put(input int r, input int c, input int v);
        grid[r][c] <= v[2:0];
    endtask

    // Called at the negedge of the accept cycle; returns at the negedge of
    // the cycle after done. With hold, lock_valid stays high throughout.
    task automatic run_commit(input int t, input int r, input int orow, input int ocol, input bit hold);
        int i;
        int wcnt;
        int acc;
        bit seen;
        check_eq("ready_idle", 32'(lock_ready), 1);
        build_model(t, r, orow, ocol);
        piece_type = t[2:0];
        piece_rot  = r[1:0];
        origin_row = orow[5:0];
        origin_col = ocol[4:0];
        lock_valid = 1'b1;
        @(negedge clk);
        if (!hold) lock_valid = 1'b0;
        i = 1; wcnt = 0; acc = 0; seen = 1'b0;
        check_eq("busy_start", 32'(busy), 1);
        check_eq("ready_busy", 32'(lock_ready), 0);
        check_eq("lines_clr", 32'(lines_cleared), 0);
        check_eq("oob_clr", 32'(oob), 0);
        while (!seen && i < 3000) begin
            if (i <= 4 && wr_en) wcnt++;
            if (lock_valid && lock_ready) acc++;
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                i++;
            end
        end
        if (!seen) begin
            check_eq("done_timeout", 32'(seen), 1);
        end else begin
            check_eq("latency", i + 1, 1 + 4 + 200 + 10 * exp_copied + 10 * exp_lines + 1);
            check_eq("piece_writes", wcnt, exp_writes);
            check_eq("lines", 32'(lines_cleared), exp_lines);
            check_eq("oob", 32'(oob), exp_oob);
            for (int rr = 0; rr < 20; rr++) check_eq($sformatf("row%0d", rr), 32'(grid_row(rr)), 32'(exp_rows[rr]));
            if (hold) check_eq("single_accept", acc, 0);
        end
        $display("commit type=%0d rot=%0d origin=(%0d,%0d) lines=%0d oob=%0d cycles=%0d",
                 t, r, orow, ocol, lines_cleared, oob, i + 1);
        @(negedge clk);
        check_eq("ready_after", 32'(lock_ready), 1);
        check_eq("busy_after", 32'(busy), 0);
    endtask

    initial begin
        int i;
        int ndone;
        int t;
        int r;
        int orow;
        int ocol;

        reset = 1'b1; lock_valid = 1'b0;
        piece_type = '0; piece_rot = '0; origin_row = '0; origin_col = '0;
        clear_grid();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", 32'(lock_ready), 1);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_wr_en", 32'(wr_en), 0);
        check_eq("rst_lines", 32'(lines_cleared), 0);
        check_eq("rst_oob", 32'(oob), 0);
        check_eq("rst_addr", 32'({rd_row, rd_col, wr_row, wr_col}), 0);

        // O on an empty floor.
        run_commit(2, 0, 18, 4, 1'b0);

        // Single line clear with the row above shifted down.
        clear_grid();
        for (int c = 0; c < 6; c++) put(19, c, 3);
        put(18, 0, 5);
        @(negedge clk);
        run_commit(1, 0, 18, 6, 1'b0);

        // Vertical I completes four rows at once.
        clear_grid();
        for (int rr = 16; rr < 20; rr++) for (int c = 0; c < 9; c++) put(rr, c, 4);
        @(negedge clk);
        run_commit(1, 1, 16, 7, 1'b0);

        // Horizontal I hanging off the right edge.
        clear_grid();
        @(negedge clk);
        run_commit(1, 0, 5, 8, 1'b0);

        // lock_valid held across a commit: exactly one accept, next right after done.
        clear_grid();
        @(negedge clk);
        run_commit(2, 0, 18, 4, 1'b1);
        run_commit(2, 0, 18, 4, 1'b0);

        // Reset while compaction is copying rows.
        clear_grid();
        for (int c = 0; c < 6; c++) put(19, c, 3);
        put(18, 0, 5);
        @(negedge clk);
        piece_type = 3'd1; piece_rot = 2'd0; origin_row = 6'd18; origin_col = 5'd6;
        lock_valid = 1'b1;
        @(negedge clk);
        lock_valid = 1'b0;
        i = 1;
        while (!(i > 4 && wr_en) && i < 1000) begin
            @(negedge clk);
            i++;
        end
        check_eq("copy_reached", 32'(i > 4 && wr_en), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("mid_rst_busy", 32'(busy), 0);
        check_eq("mid_rst_wr_en", 32'(wr_en), 0);
        check_eq("mid_rst_ready", 32'(lock_ready), 1);
        check_eq("mid_rst_lines", 32'(lines_cleared), 0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check_eq("mid_rst_no_done", ndone, 0);
        $display("reset during copy: busy=%0d wr_en=%0d done_pulses=%0d", busy, wr_en, ndone);

        // Random commits over a densely filled bottom.
        for (int n = 0; n < 12; n++) begin
            clear_grid();
            for (int rr = 13; rr < 20; rr++)
                for (int c = 0; c < 10; c++)
                    put(rr, c, ($urandom_range(0, 99) < 85) ? int'($urandom_range(1, 7)) : 0);
            @(negedge clk);
            t    = int'($urandom_range(0, 7));
            r    = int'($urandom_range(0, 3));
            orow = ($urandom_range(0, 1) == 1) ? int'($urandom_range(10, 18)) : int'($urandom_range(0, 24)) - 4;
            ocol = int'($urandom_range(0, 14)) - 4;
            run_commit(t, r, orow, ocol, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
